// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Valid/ready pipeline latch for one vector-ALU bundle, with a
//                2-entry skid, synchronous flush and a saturating stall count.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int DATA_W  = 64,
    parameter int NUM_OPS = 2,
    parameter int REG_W   = 4,
    parameter int CTRL_W  = 14,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      cnt_clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [REG_W-1:0]          in_rd,
    input  logic [NUM_OPS*REG_W-1:0]  in_rs,
    input  logic [NUM_OPS*DATA_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [REG_W-1:0]          out_rd,
    output logic [NUM_OPS*REG_W-1:0]  out_rs,
    output logic [NUM_OPS*DATA_W-1:0] out_data,
    output logic [1:0]                occ,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int              c_bundle_w = CTRL_W + REG_W + NUM_OPS*REG_W + NUM_OPS*DATA_W;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    // Encoding equals the number of held entries, so occ is the state itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic [c_bundle_w-1:0]   main_q, main_d;
    logic [c_bundle_w-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_out_valid;
    logic [c_bundle_w-1:0]   w_in_bundle;

    assign w_in_bundle = {in_ctrl, in_rd, in_rs, in_data};
    assign w_out_valid = (state_q != S_EMPTY);
    assign w_in_fire   = in_valid && in_ready_q;
    assign w_out_fire  = w_out_valid && out_ready;

    // Next-state and payload steering; in_* is only ever selected on w_in_fire.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        state_d = S_ONE;
                        main_d  = w_in_bundle;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        state_d = S_TWO;
                        skid_d  = w_in_bundle;
                    end else if (w_in_fire && w_out_fire) begin
                        main_d  = w_in_bundle;
                    end else if (w_out_fire) begin
                        state_d = S_EMPTY;
                        main_d  = '0;
                    end
                end
                S_TWO: begin
                    if (w_out_fire) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Registered ready keeps it independent of out_ready and low during reset.
    always_comb begin
        in_ready_d = (state_d != S_TWO);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (w_out_valid && !out_ready && !flush && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = w_out_valid;
    assign occ       = state_q;
    assign stall_cnt = cnt_q;
    assign {out_ctrl, out_rd, out_rs, out_data} = main_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Scoreboard bench for pipe_stage_skid (directed vectors).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int DATA_W  = 64;
    localparam int NUM_OPS = 2;
    localparam int REG_W   = 4;
    localparam int CTRL_W  = 14;
    localparam int CNT_W   = 4;
    localparam int BW      = CTRL_W + REG_W + NUM_OPS*REG_W + NUM_OPS*DATA_W;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic                      cnt_clr;
    logic                      in_valid;
    logic                      in_ready;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [REG_W-1:0]          in_rd;
    logic [NUM_OPS*REG_W-1:0]  in_rs;
    logic [NUM_OPS*DATA_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [REG_W-1:0]          out_rd;
    logic [NUM_OPS*REG_W-1:0]  out_rs;
    logic [NUM_OPS*DATA_W-1:0] out_data;
    logic [1:0]                occ;
    logic [CNT_W-1:0]          stall_cnt;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    logic [BW-1:0] exp_q[$];

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .NUM_OPS(NUM_OPS),
        .REG_W  (REG_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .cnt_clr  (cnt_clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_rd    (in_rd),
        .in_rs    (in_rs),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_rd   (out_rd),
        .out_rs   (out_rs),
        .out_data (out_data),
        .occ      (occ),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int k);
        logic [CTRL_W-1:0]         c;
        logic [REG_W-1:0]          d;
        logic [NUM_OPS*REG_W-1:0]  s;
        logic [NUM_OPS*DATA_W-1:0] o;
        c = CTRL_W'(14'h100 + k);
        d = REG_W'(k);
        s = {REG_W'(k + 1), REG_W'(k)};
        o = {64'hA000_0000_0000_0000 + 64'(k), 64'(k)};
        return {c, d, s, o};
    endfunction

    task automatic drive(input int k);
        {in_ctrl, in_rd, in_rs, in_data} = mk(k);
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_ctrl  = 'x;
        in_rd    = 'x;
        in_rs    = 'x;
        in_data  = 'x;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side of the scoreboard: record each accepted bundle.
    always @(posedge clk) begin
        if (rst) begin
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back({in_ctrl, in_rd, in_rs, in_data});
        end
    end

    always @(negedge rst) exp_q.delete();

    // Monitor: compare every output transfer; check bubble encoding otherwise.
    always @(negedge clk) begin
        if (rst) begin
            chk("valid_vs_occ", 256'(out_valid), 256'(occ != 2'd0));
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 256'({out_ctrl, out_rd, out_rs, out_data}), 256'(0));
                end else begin
                    chk("payload", 256'({out_ctrl, out_rd, out_rs, out_data}), 256'(exp_q.pop_front()));
                    rx_cnt++;
                end
            end else if (!out_valid) begin
                chk("bubble_zero", 256'({out_ctrl, out_rd, out_rs, out_data}), 256'(0));
            end
        end
    end

    bit saw_full;

    task automatic run_seq(input int first, input int n, input int st_start, input int st_len);
        int  idx;
        int  cyc;
        bit  acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 50) begin
            out_ready = !(cyc >= st_start && cyc < st_start + st_len);
            drive(first + idx);
            @(negedge clk);
            if (occ == 2'd2 && !in_ready) saw_full = 1'b1;
            acc = in_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        chk("seq_done", 256'(idx), 256'(n));
        idle();
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        bit ready_low;
        rst       = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        saw_full  = 1'b0;
        idle();

        // Reset state
        #23;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_occ", 256'(occ), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_stall", 256'(stall_cnt), 256'(0));
        chk("rst_payload", 256'({out_ctrl, out_rd, out_rs, out_data}), 256'(0));
        #4;
        rst = 1'b1;
        #1;
        chk("ready_before_edge", 256'(in_ready), 256'(0));
        step();
        chk("ready_after_edge", 256'(in_ready), 256'(1));

        // Basic single bundle
        in_ctrl  = 14'h0A5;
        in_rd    = 4'h3;
        in_rs    = 8'h21;
        in_data  = {64'h1111, 64'h2222};
        in_valid = 1'b1;
        step();
        idle();
        chk("basic_valid", 256'(out_valid), 256'(1));
        chk("basic_occ", 256'(occ), 256'(1));
        chk("basic_ctrl", 256'(out_ctrl), 256'(14'h0A5));
        chk("basic_rd", 256'(out_rd), 256'(4'h3));
        chk("basic_data", 256'(out_data), 256'({64'h1111, 64'h2222}));
        repeat (2) step();

        // Streaming at full rate
        ready_low = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drive(k);
            if (!in_ready) ready_low = 1'b1;
            step();
        end
        idle();
        repeat (3) step();
        chk("stream_ready_low", 256'(ready_low), 256'(0));
        chk("stream_stall", 256'(stall_cnt), 256'(0));
        chk("stream_rx", 256'(rx_cnt), 256'(9));

        // Backpressure into the skid entry
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        run_seq(1, 4, 1, 3);
        chk("bp_full_seen", 256'(saw_full), 256'(1));
        chk("bp_stall", 256'(stall_cnt), 256'(3));
        chk("bp_rx", 256'(rx_cnt), 256'(13));

        // Flush with both entries held
        out_ready = 1'b0;
        drive(5);
        step();
        drive(6);
        step();
        chk("flush_pre_occ", 256'(occ), 256'(2));
        drive(7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush_occ", 256'(occ), 256'(0));
        chk("flush_valid", 256'(out_valid), 256'(0));
        chk("flush_payload", 256'({out_ctrl, out_rd, out_rs, out_data}), 256'(0));
        // Flush from ONE while a bundle is accepted and one is presented
        out_ready = 1'b1;
        drive(8);
        step();
        drive(9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush1_occ", 256'(occ), 256'(0));
        repeat (3) step();
        chk("flush_rx", 256'(rx_cnt), 256'(13));
        chk("flush_q_empty", 256'(exp_q.size()), 256'(0));

        // Stall counter saturation and clear
        out_ready = 1'b0;
        cnt_clr   = 1'b1;
        drive(10);
        step();
        cnt_clr = 1'b0;
        idle();
        repeat (20) step();
        chk("sat_stall", 256'(stall_cnt), 256'(15));
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_stall", 256'(stall_cnt), 256'(0));
        step();
        chk("clr_then_stall", 256'(stall_cnt), 256'(1));
        out_ready = 1'b1;
        repeat (3) step();
        chk("sat_rx", 256'(rx_cnt), 256'(14));

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(11);
        step();
        drive(12);
        step();
        idle();
        chk("arst_pre_occ", 256'(occ), 256'(2));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 256'(out_valid), 256'(0));
        chk("arst_occ", 256'(occ), 256'(0));
        chk("arst_ready", 256'(in_ready), 256'(0));
        chk("arst_payload", 256'({out_ctrl, out_rd, out_rs, out_data}), 256'(0));
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        chk("arst_ready_rise", 256'(in_ready), 256'(1));
        drive(13);
        step();
        idle();
        repeat (3) step();
        chk("final_rx", 256'(rx_cnt), 256'(15));
        chk("final_q_empty", 256'(exp_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed decode/execute pipeline latch.
- Registers one vector-ALU instruction bundle (control word, destination index, NUM_OPS source indices and operands) between two pipeline stages.
- Adds valid/ready flow control, a 2-entry skid buffer giving full throughput under backpressure, synchronous flush (bubble insertion) and a stall-cycle counter.
- Instantiated at each stage boundary of the ASIP pipeline.

Parameters:
- DATA_W, 64, width of each operand.
- NUM_OPS, 2, number of source operands/indices carried (1..4).
- REG_W, 4, register-index width.
- CTRL_W, 14, packed control-word width (conEn, jmpF, ALU control, write enables, mux selects).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept a bundle.
- in_ctrl  input  CTRL_W  control word.
- in_rd  input  REG_W  destination index.
- in_rs  input  NUM_OPS*REG_W  source indices, op0 in LSBs.
- in_data  input  NUM_OPS*DATA_W  operands, op0 in LSBs.
- out_valid  output  1  downstream bundle valid.
- out_ready  input  1  downstream accepts.
- out_ctrl, out_rd, out_rs, out_data  output  same widths as inputs  registered bundle.
- occ  output  2  entries held (0, 1 or 2).
- stall_cnt  output  CNT_W  saturating count of backpressured cycles.

Behaviour:
- Storage: main register (drives out_*) plus one skid register. States: EMPTY (occ=0), ONE (main only, occ=1), TWO (main+skid, occ=2).
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Payload must be sampled only on a transfer.
- in_ready = (state != TWO). It is a pure function of registered state, never combinational from out_ready.
- out_valid = (state != EMPTY).
- Transitions (absent flush), with in = input transfer and out = output transfer:
  - EMPTY: in -> ONE, main <= input.
  - ONE: in && !out -> TWO, skid <= input. in && out -> ONE, main <= input. !in && out -> EMPTY.
  - TWO: out -> ONE, main <= skid. No input transfer is possible in TWO.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Back-to-back throughput is 1 bundle/cycle with out_ready held high.
  - A single-cycle out_ready deassertion loses no data.
- Bubble encoding: when the state becomes EMPTY (drain or flush), main payload loads all-zero. out_ctrl/out_rd/out_rs/out_data therefore read 0 whenever out_valid=0, so write enables are 0 (NOP).
- Flush:
  - Has priority over all transfers.
  - Next state is EMPTY and main/skid payloads are zeroed.
  - in_ready keeps its state-derived value in the flush cycle. A bundle accepted that cycle is discarded.
  - A bundle presented on out_* that cycle counts as transferred only if out_ready=1. Downstream must treat it as killed.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_W-1.
  - cnt_clr takes priority over increment and sets it to 0.
  - Flush does not clear it.
- Reset (rst=0, asynchronous): state EMPTY, occ=0, out_valid=0, all payload outputs 0, stall_cnt=0.
- in_ready is 0 while rst=0. It rises on the first clk edge after rst deasserts (in_ready is registered, reset value 0, set in EMPTY).
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- X-safety: payload registers must not load when no input transfer occurs. in_* may be X while in_valid=0.

Test Plan:
- Reset/basic: assert rst=0, then release. Expect out_valid=0, all outputs 0, occ=0. Then in_valid=1 with in_ctrl=14'h0A5, in_rd=4'h3, in_data={64'h1111,64'h2222}. Expect out_valid=1 next cycle with identical payload, occ=1.
- Streaming: 8 bundles with data 1..8 on consecutive cycles, out_ready=1. Expect outputs 1..8 on consecutive cycles, in_ready never low, stall_cnt=0.
- Backpressure/skid: stream 1,2,3,4 with out_ready=0 from cycle 2 for 3 cycles.
  - Expect occ=2 and in_ready=0 after bundle 2 is held.
  - stall_cnt=3.
  - On out_ready=1, output order is 1,2,3,4 with no loss or duplication.
- Flush: occ=2 holding 5,6, assert flush with in_valid=1 (data 7). Expect next cycle occ=0, out_valid=0, out_* = 0, bundle 7 absent from the output stream.
- Counter saturation/clear: CNT_W=4, out_ready=0 for 20 cycles with occ>=1. Expect stall_cnt=15. Then cnt_clr=1 for 1 cycle. Expect stall_cnt=0, or 1 if still stalled in the following cycle.
- Async reset mid-flight: with occ=2, drop rst between clock edges. Expect out_valid=0 and occ=0 before the next posedge, and in_ready=1 on the first edge after release.
